// File: rtl/ime_pkg.sv
// Shared types and constants for the IME stream arbiter.
package ime_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    HOST  = 2'd1,
    BIST  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  localparam logic       SRC_HOST     = 1'b0;
  localparam logic       SRC_BIST     = 1'b1;
  localparam logic [7:0] POISON_TUSER = 8'hFF;

endpackage

// File: rtl/ime_stream_arbiter.sv
// Frame-atomic arbiter between the host stream and the BIST stimulus feeding
// the IME datapath. Ownership is granted per frame with round-robin on ties.
// A stalled or orphaned frame is closed with one poisoned tlast beat.
module ime_stream_arbiter
  import ime_pkg::*;
#(
  parameter int W_P     = 16,
  parameter int W_LOG   = 16,
  parameter int W_DATA  = 2*W_P + W_LOG,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_DATA-1:0] host_tdata,
  input  logic [7:0]        host_tuser,
  input  logic              host_tvalid,
  input  logic              host_tlast,
  output logic              host_tready,
  input  logic              bist_active,
  input  logic [W_DATA-1:0] bist_tdata,
  input  logic [7:0]        bist_tuser,
  input  logic              bist_tvalid,
  input  logic              bist_tlast,
  output logic              bist_tready,
  input  logic              cfg_bist_excl,
  output logic [W_DATA-1:0] m_tdata,
  output logic [7:0]        m_tuser,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              m_tsrc,
  output logic              abort_pulse,
  output logic [15:0]       frame_cnt_host,
  output logic [15:0]       frame_cnt_bist
);

  localparam int            IW       = $clog2(TIMEOUT);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  arb_state_t    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          src_q, src_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [15:0]   cnt_host_q, cnt_host_d;
  logic [15:0]   cnt_bist_q, cnt_bist_d;

  logic req_h, req_b;
  logic own_b, own_valid, own_last;

  assign req_h = host_tvalid & ~(cfg_bist_excl & bist_active);
  assign req_b = bist_tvalid & bist_active;

  // Owner view of the stream; only meaningful in HOST/BIST.
  assign own_b     = (state_q == BIST);
  assign own_valid = own_b ? bist_tvalid : host_tvalid;
  assign own_last  = own_b ? bist_tlast  : host_tlast;

  assign m_tsrc         = src_q;
  assign frame_cnt_host = cnt_host_q;
  assign frame_cnt_bist = cnt_bist_q;

  // Next-state, grant bookkeeping and the output mux.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    src_d        = src_q;
    idle_d       = idle_q;
    cnt_host_d   = cnt_host_q;
    cnt_bist_d   = cnt_bist_q;
    m_tvalid     = 1'b0;
    m_tlast      = 1'b0;
    m_tdata      = '0;
    m_tuser      = '0;
    host_tready  = 1'b0;
    bist_tready  = 1'b0;
    abort_pulse  = 1'b0;

    case (state_q)
      ARB: begin
        idle_d = '0;
        // Tie goes to whichever source did not own the previous frame.
        if (req_h && (!req_b || last_grant_q == SRC_BIST)) begin
          state_d      = HOST;
          last_grant_d = SRC_HOST;
          src_d        = SRC_HOST;
        end else if (req_b) begin
          state_d      = BIST;
          last_grant_d = SRC_BIST;
          src_d        = SRC_BIST;
        end
      end

      HOST, BIST: begin
        m_tvalid = own_valid;
        m_tlast  = own_last;
        m_tdata  = own_b ? bist_tdata : host_tdata;
        m_tuser  = own_b ? bist_tuser : host_tuser;
        if (own_b) bist_tready = m_tready;
        else       host_tready = m_tready;

        // Only an empty owner counts as idle; backpressure does not.
        idle_d = own_valid ? '0 : idle_q + 1'b1;

        // A completing tlast beat takes priority over either abort cause.
        if (own_valid && own_last && m_tready) begin
          if (own_b) cnt_bist_d = cnt_bist_q + 16'd1;
          else       cnt_host_d = cnt_host_q + 16'd1;
          state_d = ARB;
        end else if ((!own_valid && idle_q == IDLE_MAX) || (own_b && !bist_active)) begin
          idle_d  = '0;
          state_d = ABORT;
        end
      end

      ABORT: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = POISON_TUSER;
        if (m_tready) begin
          abort_pulse = 1'b1;
          idle_d      = '0;
          state_d     = ARB;
        end
      end

      default: state_d = ARB;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      last_grant_q <= SRC_BIST;
      src_q        <= SRC_HOST;
      idle_q       <= '0;
      cnt_host_q   <= '0;
      cnt_bist_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      idle_q       <= idle_d;
      cnt_host_q   <= cnt_host_d;
      cnt_bist_q   <= cnt_bist_d;
    end
  end

endmodule
